// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Purpose  : Sequences a Dioptase core from start to halt. Gates fetch and
//            pipeline advance, counts cycles spent in RUN+DRAIN (saturating),
//            enforces a programmable cycle limit, drains the pipeline after a
//            halt and captures the architectural return value.
// Ports    : clk          - core clock, rising edge
//            rst_n        - asynchronous active-low reset
//            start        - begins/restarts a run from IDLE, DONE or TIMEOUT
//            cycle_limit  - max RUN cycles, 0 = unlimited, sampled each cycle
//            halt_req     - writeback retired a halt instruction
//            ret_val      - return register value, valid with halt_req
//            pipe_empty   - nothing in flight and store path drained
//            step_mode    - (optional) single-step enable in RUN
//            step         - (optional) one-cycle step strobe
//            cpu_run      - pipeline advance enable
//            fetch_en     - fetch / PC-update enable
//            done         - run finished (normal or timeout)
//            timed_out    - run ended by cycle limit or drain timeout
//            result       - ret_val captured at halt
//            cycles       - RUN+DRAIN cycle count, saturating
// Options  : define RUN_CONTROLLER_STEP_EN to add step_mode/step inputs.
// Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             halt_req,
  input  logic [31:0]      ret_val,
  input  logic             pipe_empty,
`ifdef RUN_CONTROLLER_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             cpu_run,
  output logic             fetch_en,
  output logic             done,
  output logic             timed_out,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_MAX - 1);

  state_t           state;
  logic             run_q;
  logic             fetch_q;
  logic [7:0]       drain_cnt;
  logic             advance;
  logic             limit_hit;
  logic [CNT_W-1:0] cycles_inc;

`ifdef RUN_CONTROLLER_STEP_EN
  // In step mode a RUN cycle only "happens" when step is high; DRAIN is
  // never gated, so the gate is forced open outside RUN.
  assign advance  = !step_mode || step;
  assign cpu_run  = run_q & (advance | (state != S_RUN));
  assign fetch_en = fetch_q & advance;
`else
  assign advance  = 1'b1;
  assign cpu_run  = run_q;
  assign fetch_en = fetch_q;
`endif

  // Counter holds at all-ones instead of wrapping.
  assign cycles_inc = (&cycles) ? cycles : cycles + CNT_ONE;

  // Compare the pre-increment count against limit-1 so that exactly
  // cycle_limit RUN cycles elapse; equality only, so lowering the limit
  // below the current count never fires retroactively.
  assign limit_hit = (cycle_limit != '0) && (cycles == cycle_limit - CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      run_q     <= 1'b0;
      fetch_q   <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      result    <= '0;
      cycles    <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state     <= S_RUN;
            run_q     <= 1'b1;
            fetch_q   <= 1'b1;
            done      <= 1'b0;
            timed_out <= 1'b0;
            result    <= '0;
            cycles    <= '0;
            drain_cnt <= '0;
          end
        end

        S_RUN: begin
          if (advance) begin
            cycles <= cycles_inc;
            // Halt wins over a simultaneous limit hit.
            if (halt_req) begin
              state     <= S_DRAIN;
              result    <= ret_val;
              fetch_q   <= 1'b0;
              drain_cnt <= '0;
            end else if (limit_hit) begin
              state     <= S_TIMEOUT;
              run_q     <= 1'b0;
              fetch_q   <= 1'b0;
              done      <= 1'b1;
              timed_out <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          cycles <= cycles_inc;
          // Empty is checked first so an empty pipe on the last allowed
          // drain cycle still completes normally.
          if (pipe_empty) begin
            state <= S_DONE;
            run_q <= 1'b0;
            done  <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            state     <= S_TIMEOUT;
            run_q     <= 1'b0;
            done      <= 1'b1;
            timed_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end

        default: begin
          state     <= S_IDLE;
          run_q     <= 1'b0;
          fetch_q   <= 1'b0;
          done      <= 1'b0;
          timed_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_controller
// Purpose  : Self-checking bench for run_controller. Table of run scenarios
//            with expected completion status pushed to a scoreboard queue at
//            start and popped when done rises, plus hand-written sequences
//            for asynchronous reset, mid-run limit changes and stepping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_controller;

  localparam int CNT_W     = 32;
  localparam int DRAIN_MAX = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cycle_limit = '0;
  logic             halt_req = 1'b0;
  logic [31:0]      ret_val = '0;
  logic             pipe_empty = 1'b0;
`ifdef RUN_CONTROLLER_STEP_EN
  logic             step_mode = 1'b0;
  logic             step = 1'b0;
`endif
  logic             cpu_run;
  logic             fetch_en;
  logic             done;
  logic             timed_out;
  logic [31:0]      result;
  logic [CNT_W-1:0] cycles;

  run_controller #(.DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cycle_limit (cycle_limit),
    .halt_req    (halt_req),
    .ret_val     (ret_val),
    .pipe_empty  (pipe_empty),
`ifdef RUN_CONTROLLER_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .cpu_run     (cpu_run),
    .fetch_en    (fetch_en),
    .done        (done),
    .timed_out   (timed_out),
    .result      (result),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] limit;
    int          halt_at;    // RUN cycle carrying halt_req, 0 = none
    logic [31:0] ret;
    int          empty_at;   // DRAIN cycle with pipe_empty=1, 0 = never
    logic        exp_to;
    logic [31:0] exp_result;
    logic [31:0] exp_cycles;
  } vec_t;

  typedef struct {
    logic        to;
    logic [31:0] result;
    logic [31:0] cycles;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic to, input logic [31:0] res, input logic [31:0] cyc);
    exp_t e;
    e.to = to; e.result = res; e.cycles = cyc;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the finished run.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " done"},      64'(done),      64'(1'b1));
      check({tag, " timed_out"}, 64'(timed_out), 64'(e.to));
      check({tag, " result"},    64'(result),    64'(e.result));
      check({tag, " cycles"},    64'(cycles),    64'(e.cycles));
      check({tag, " cpu_run"},   64'(cpu_run),   64'(1'b0));
      check({tag, " fetch_en"},  64'(fetch_en),  64'(1'b0));
    end
  endtask

  task automatic bound_fail(input string tag);
    tests++; fails++;
    $display("FAIL %s: done not seen within cycle bound", tag);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit halts;
    bit finished;
    finished = 1'b0;
    halts = (v.halt_at != 0) && (v.limit == 0 || v.halt_at <= int'(v.limit));
    @(negedge clk);
    start = 1'b1;
    cycle_limit = v.limit;
    push_exp(v.exp_to, v.exp_result, v.exp_cycles);
    @(negedge clk);
    start = 1'b0;
    // First RUN cycle: one-cycle start latency and cleared status.
    check({tag, " cpu_run@start"},  64'(cpu_run),  64'(1'b1));
    check({tag, " fetch_en@start"}, 64'(fetch_en), 64'(1'b1));
    check({tag, " cleared cycles"}, 64'(cycles),   64'(0));
    check({tag, " cleared result"}, 64'(result),   64'(0));
    check({tag, " cleared done"},   64'(done),     64'(1'b0));
    for (int k = 1; k <= 3000 && !finished; k++) begin
      if (halts && k > v.halt_at) begin
        check({tag, " drain fetch_en"}, 64'(fetch_en), 64'(1'b0));
        check({tag, " drain cpu_run"},  64'(cpu_run),  64'(1'b1));
      end
      // A second halt_req in the first DRAIN cycle must be ignored.
      halt_req   = (k == v.halt_at) || (halts && k == v.halt_at + 1);
      ret_val    = (k == v.halt_at) ? v.ret : 32'hBAD0_0000;
      pipe_empty = halts && (v.empty_at != 0) && (k == v.halt_at + v.empty_at);
      @(negedge clk);
      if (done) finished = 1'b1;
    end
    halt_req = 1'b0;
    pipe_empty = 1'b0;
    if (!finished) bound_fail(tag);
    pop_check(tag);
  endtask

  initial begin
    vecs[0] = '{32'd0,   10, 32'h0000_002A, 2,  1'b0, 32'h0000_002A, 32'd12};
    vecs[1] = '{32'd500, 0,  32'h0,         0,  1'b1, 32'h0,         32'd500};
    vecs[2] = '{32'd5,   5,  32'h0000_0055, 1,  1'b0, 32'h0000_0055, 32'd6};
    vecs[3] = '{32'd0,   3,  32'hDEAD_BEEF, 0,  1'b1, 32'hDEAD_BEEF, 32'd19};
    vecs[4] = '{32'd1,   0,  32'h0,         0,  1'b1, 32'h0,         32'd1};
    vecs[5] = '{32'd0,   4,  32'h0000_0007, 16, 1'b0, 32'h0000_0007, 32'd20};
    vecs[6] = '{32'd3,   1,  32'h0000_0001, 1,  1'b0, 32'h0000_0001, 32'd2};
    vecs[7] = '{32'd8,   9,  32'h0000_0077, 1,  1'b1, 32'h0,         32'd8};

    // Reset state
    #1;
    check("reset cpu_run",   64'(cpu_run),   64'(1'b0));
    check("reset fetch_en",  64'(fetch_en),  64'(1'b0));
    check("reset done",      64'(done),      64'(1'b0));
    check("reset timed_out", 64'(timed_out), 64'(1'b0));
    check("reset result",    64'(result),    64'(0));
    check("reset cycles",    64'(cycles),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle cpu_run", 64'(cpu_run), 64'(1'b0));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-RUN aborts asynchronously.
    @(negedge clk); start = 1'b1; cycle_limit = '0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstrun cpu_run",  64'(cpu_run),  64'(1'b0));
    check("rstrun fetch_en", 64'(fetch_en), 64'(1'b0));
    check("rstrun cycles",   64'(cycles),   64'(0));
    check("rstrun done",     64'(done),     64'(1'b0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rstrun idle", 64'(cpu_run), 64'(1'b0));
    run_vec(vecs[0], "restart");

    // Reset mid-DRAIN clears captured result.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); halt_req = 1'b1; ret_val = 32'h0000_0099;
    @(negedge clk); halt_req = 1'b0;
    check("drain fetch_en", 64'(fetch_en), 64'(1'b0));
    check("drain cpu_run",  64'(cpu_run),  64'(1'b1));
    check("drain result",   64'(result),   64'(32'h99));
    check("drain cycles",   64'(cycles),   64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("rstdrain cpu_run",   64'(cpu_run),   64'(1'b0));
    check("rstdrain result",    64'(result),    64'(0));
    check("rstdrain timed_out", 64'(timed_out), 64'(1'b0));
    @(negedge clk); rst_n = 1'b1;

    // Limit lowered below the count never fires; a later match does.
    begin
      bit finished;
      finished = 1'b0;
      @(negedge clk); start = 1'b1; cycle_limit = '0;
      push_exp(1'b1, 32'h0, 32'd35);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      cycle_limit = 32'd5;
      repeat (20) @(negedge clk);
      check("lowlimit fetch_en", 64'(fetch_en), 64'(1'b1));
      check("lowlimit done",     64'(done),     64'(1'b0));
      cycle_limit = 32'd35;
      for (int k = 0; k < 50 && !finished; k++) begin
        @(negedge clk);
        if (done) finished = 1'b1;
      end
      if (!finished) bound_fail("relimit");
      pop_check("relimit");
      cycle_limit = '0;
    end

`ifdef RUN_CONTROLLER_STEP_EN
    begin
      bit finished;
      finished = 1'b0;
      step_mode = 1'b1;
      @(negedge clk); start = 1'b1; cycle_limit = 32'd3;
      push_exp(1'b1, 32'h0, 32'd3);
      @(negedge clk); start = 1'b0;
      for (int c = 1; c <= 20 && !finished; c++) begin
        step = (c == 3) || (c == 9) || (c == 15);
        #1;
        check($sformatf("step cpu_run c%0d", c),  64'(cpu_run),  64'(step));
        check($sformatf("step fetch_en c%0d", c), 64'(fetch_en), 64'(step));
        @(negedge clk);
        step = 1'b0;
        if (done) finished = 1'b1;
      end
      if (!finished) bound_fail("step");
      pop_check("step");
      step_mode = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
